// File: rtl/seq_detect_if.sv
// seq_detect_if: config/stream/result bundle for seq_detect_fsm; cfg_mask present only with SEQDET_MASK_EN
interface seq_detect_if #(
  parameter int N = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(N + 1);
  logic cfg_load;
  logic [N-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic cfg_overlap;
`ifdef SEQDET_MASK_EN
  logic [N-1:0] cfg_mask;
`endif
  logic clear;
  logic w_valid;
  logic w;
  logic z;
  logic armed;
  logic [CNT_W-1:0] match_cnt;
  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
`ifdef SEQDET_MASK_EN
    output cfg_mask,
`endif
    output clear, w_valid, w,
    input z, armed, match_cnt
  );
  modport slave (
    input cfg_load, cfg_pattern, cfg_len, cfg_overlap,
`ifdef SEQDET_MASK_EN
    input cfg_mask,
`endif
    input clear, w_valid, w,
    output z, armed, match_cnt
  );
endinterface

// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: programmable serial pattern detector with saturating match count; SEQDET_MASK_EN adds a don't-care mask
module seq_detect_fsm #(
  parameter int N = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  seq_detect_if.slave bus
);
  localparam int LEN_W = $clog2(N + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [N-1:0] hist_q, hist_d, pat_q, pat_d, new_hist, care;
  logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d;
  logic [LEN_W:0] fill_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ovl_q, ovl_d, z_q, z_d, cfg_ok, sample, hit;
`ifdef SEQDET_MASK_EN
  logic [N-1:0] mask_q, mask_d;
  assign care = ~({N{1'b1}} << len_q) & ~mask_q;
`else
  assign care = ~({N{1'b1}} << len_q);
`endif
  assign cfg_ok = bus.cfg_load && bus.cfg_len != '0 && bus.cfg_len <= LEN_W'(N);
  assign sample = state_q == RUN && bus.w_valid && !bus.cfg_load && !bus.clear;
  assign new_hist = {hist_q[N-2:0], bus.w};
  assign fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign hit = fill_inc >= {1'b0, len_q} && ((new_hist ^ pat_q) & care) == '0;
  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hist_q <= '0;
      pat_q <= '0;
      len_q <= '0;
      fill_q <= '0;
      ovl_q <= 1'b0;
      z_q <= 1'b0;
      cnt_q <= '0;
`ifdef SEQDET_MASK_EN
      mask_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hist_q <= hist_d;
      pat_q <= pat_d;
      len_q <= len_d;
      fill_q <= fill_d;
      ovl_q <= ovl_d;
      z_q <= z_d;
      cnt_q <= cnt_d;
`ifdef SEQDET_MASK_EN
      mask_q <= mask_d;
`endif
    end
  end
  // Any load picks the state: good length arms, bad length drops to IDLE
  always_comb state_d = bus.cfg_load ? (cfg_ok ? RUN : IDLE) : state_q;
  // Next values: load > clear > sampling; non-overlap restarts the fill on a hit
  always_comb begin
    z_d = sample && hit;
    cnt_d = bus.cfg_load ? cnt_q : bus.clear ? '0 : (z_d && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    hist_d = cfg_ok ? '0 : sample ? new_hist : hist_q;
    fill_d = cfg_ok ? '0 : bus.cfg_load ? fill_q : bus.clear ? '0 : !sample ? fill_q :
             (z_d && !ovl_q) ? '0 : fill_inc > (LEN_W+1)'(N) ? LEN_W'(N) : fill_inc[LEN_W-1:0];
    pat_d = cfg_ok ? bus.cfg_pattern : pat_q;
    len_d = cfg_ok ? bus.cfg_len : len_q;
    ovl_d = cfg_ok ? bus.cfg_overlap : ovl_q;
`ifdef SEQDET_MASK_EN
    mask_d = cfg_ok ? bus.cfg_mask : mask_q;
`endif
  end
  assign bus.z = z_q;
  assign bus.armed = state_q == RUN;
  assign bus.match_cnt = cnt_q;
endmodule

// File: doc/seq_detect_fsm.md
Name: seq_detect_fsm

Overview:
- Parametrised serial pattern-detector FSM; successor to the fixed six-state run detector.
- Samples a 1-bit serial stream `w` (qualified by `w_valid`) and compares it against a runtime-programmed pattern of 1..N bits.
- Raises a registered Moore-style `z` for one cycle per match and keeps a saturating match count.
- Sits beside control-path sequencers that need in-band framing or sync-word detection.

Parameters:
- N, 8, maximum pattern length in bits (2..32).
- CNT_W, 8, width of the saturating match counter.
- LEN_W, $clog2(N+1), width of the `cfg_len` field (derived; do not override).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- cfg_load, input, 1, single-cycle pulse that latches `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- cfg_pattern, input, N, pattern bits; bit [cfg_len-1] is the first (oldest) bit; bit 0 is the last (newest) bit.
- cfg_len, input, LEN_W, pattern length, 1..N.
- cfg_overlap, input, 1, 1 = overlapping matches allowed; 0 = non-overlapping.
- clear, input, 1, zeroes `match_cnt` and the history fill level; keeps the configuration.
- w_valid, input, 1, qualifies `w`.
- w, input, 1, serial data bit.
- z, output, 1, registered match strobe.
- armed, output, 1, high while in RUN.
- match_cnt, output, CNT_W, saturating count of matches.

Behaviour:
- Reset: state = IDLE; `z`=0; `armed`=0; `match_cnt`=0; history `hist`=0; `fill`=0; configuration registers = 0.
- States:
  - IDLE: `w` is ignored.
  - RUN: detecting.
- Transitions:
  - IDLE -> RUN on `cfg_load` with `cfg_len` in 1..N.
  - `cfg_load` with `cfg_len`=0 or `cfg_len`>N: rejected; the block goes to (or stays in) IDLE and the configuration is unchanged.
  - RUN -> RUN on a valid `cfg_load`: reconfigure; `hist` and `fill` reset to 0; `match_cnt` held.
  - RUN has no other exit except reset.
- Sampling (RUN, `w_valid`=1):
  - hist <= {hist[N-2:0], w}.
  - fill <= min(fill+1, N).
  - `w_valid`=0: `hist`, `fill` and `z` updates are suppressed; `z` goes to 0 that cycle.
- Match condition, evaluated on the post-shift history: (fill+1 >= cfg_len) and (new_hist[cfg_len-1:0] == pattern[cfg_len-1:0]).
- Latency: `z` is 1 in the cycle after the edge that sampled the final pattern bit. `z` is a one-cycle strobe and is never combinational from `w`.
- Overlap mode: `fill` continues to saturate normally after a match. Example: pattern 11 over stream 111 gives two matches.
- Non-overlap mode: on a match, `fill` is forced to 0, so the next match needs `cfg_len` fresh bits. Example: pattern 11 over stream 1111 gives two matches, not three.
- `match_cnt`:
  - Increments by 1 in the same edge that sets `z`.
  - Saturates at 2^CNT_W-1; at saturation `z` still pulses.
- `clear`:
  - Zeroes `match_cnt` and `fill`; `hist` is not required to clear.
  - When `clear` and a match happen in the same cycle, `clear` wins: `z`=0 and `match_cnt`=0.
- Priority within a cycle: reset > cfg_load > clear > sampling.
  - A `cfg_load` cycle ignores `w` even when `w_valid`=1.
- Length 1: every valid bit equal to `pattern[0]` matches; back-to-back `z` is legal.
- Reset mid-stream: returns to IDLE; configuration is lost.
- `armed` = (state == RUN), registered.

Optional Feature:
- Macro: SEQDET_MASK_EN.
- Defined:
  - Adds input `cfg_mask` [N-1:0], latched on `cfg_load`.
  - A mask bit of 1 makes that pattern position don't-care.
  - Compare becomes ((new_hist ^ pattern) & ~mask)[cfg_len-1:0] == 0.
  - The fill condition is unchanged.
  - An all-ones mask matches every bit once `fill` reaches `cfg_len`.
- Undefined: no `cfg_mask` port; exact compare only.

Test Plan:
- Reset then `w_valid`=1 with `w`=1 for 10 cycles, no `cfg_load` -> `z`=0, `armed`=0, `match_cnt`=0 throughout.
- `cfg_load` pattern=3'b101, len=3, overlap=1; stream 1,0,1,0,1 -> `z` high the cycle after the 3rd bit and after the 5th bit; `match_cnt`=2.
- Same stream with overlap=0 -> only the 3rd-bit match fires; `match_cnt`=1.
- Pattern 2'b11, len=2, overlap=1; stream 1,1,1 with `w_valid` dropped for 2 cycles between the 2nd and 3rd bits -> `z` after bit 2, `z`=0 during the gap, `z` after bit 3; `match_cnt`=2.
- CNT_W=2, len=1, pattern=1; six consecutive 1 bits -> `z` pulses six times; `match_cnt` stops at 3. Then assert `clear` in the same cycle as a matching bit -> `z`=0, `match_cnt`=0.
- `cfg_load` with len=0 while in RUN -> `armed`=0; subsequent matching bits produce no `z`. With SEQDET_MASK_EN defined: pattern=4'b1001, mask=4'b0110, stream 1,1,1,1 -> `z` after the 4th bit.
